// File: rtl/hatch_seq_pkg.sv
// Shared constants and state encoding for the hatch sequencer and the matrix display driver.
package hatch_seq_pkg;

   localparam int LAST_FRAME = 11;
   localparam int BLANK_NUM  = 15;
   localparam int NUM_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_INCUBATE = 2'd1,
      S_DONE     = 2'd2,
      S_FAIL     = 2'd3
   } state_e;

   // Counter width large enough to hold the larger of two second-counts.
   function automatic int cnt_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hatch_seq_if.sv
// Run/temperature inputs and frame/status outputs of the hatch sequencer.
interface hatch_seq_if;
   import hatch_seq_pkg::*;

   logic             st;
   logic             temp;
   logic [NUM_W-1:0] num;
   logic             busy;
   logic             hatched;
   logic             fail;

   modport master (output st, temp, input num, busy, hatched, fail);
   modport slave  (input st, temp, output num, busy, hatched, fail);

endinterface

// File: rtl/hatch_seq_sec_prescaler.sv
// Divides the scan clock down to a one-cycle seconds tick; clr holds the count at zero.
module sec_prescaler #(
   parameter int CLK_HZ = 1000
) (
   input  logic clk,
   input  logic clr_i,
   output logic tick_o
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [PW-1:0] presc_q;

   assign tick_o = (presc_q == PW'(CLK_HZ - 1));

   always_ff @(posedge clk) begin
      if (clr_i)       presc_q <= '0;
      else if (tick_o) presc_q <= '0;
      else             presc_q <= presc_q + 1'b1;
   end

endmodule

// File: rtl/hatch_seq.sv
// Hatch-progress sequencer: steps display frames on accumulated warm seconds, fails on sustained cold.
module hatch_seq
   import hatch_seq_pkg::*;
#(
   parameter int CLK_HZ     = 1000,
   parameter int STAGE_SEC  = 3,
   parameter int FAIL_SEC   = 10,
   parameter int LAST_FRAME = hatch_seq_pkg::LAST_FRAME,
   parameter int BLANK_NUM  = hatch_seq_pkg::BLANK_NUM
) (
   input logic         clk,
   input logic         rst,
   hatch_seq_if.slave  bus
);

   localparam int CW = cnt_w(STAGE_SEC, FAIL_SEC);

   state_e           state_q;
   logic [NUM_W-1:0] num_q;
   logic [NUM_W-1:0] frame_q;
   logic [CW-1:0]    warm_q;
   logic [CW-1:0]    cold_q;
   logic             sec_tick;
   logic             presc_clr;

   // The prescaler only runs while incubating or blinking the done frames,
   // so every entry to INCUBATE starts a full second from zero.
   assign presc_clr = rst || !((state_q == S_INCUBATE) || (state_q == S_DONE));

   sec_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
      .clk    (clk),
      .clr_i  (presc_clr),
      .tick_o (sec_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         num_q   <= '0;
         frame_q <= '0;
         warm_q  <= '0;
         cold_q  <= '0;
      end else if (state_q != S_IDLE && !bus.st) begin
         // Abort wins over any coincident tick.
         state_q <= S_IDLE;
         num_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               num_q <= '0;
               if (bus.st) begin
                  state_q <= S_INCUBATE;
                  frame_q <= '0;
                  warm_q  <= '0;
                  cold_q  <= '0;
               end
            end
            S_INCUBATE: begin
               if (sec_tick) begin
                  if (bus.temp) begin
                     cold_q <= '0;
                     if (warm_q == CW'(STAGE_SEC - 1)) begin
                        warm_q <= '0;
                        if (frame_q == NUM_W'(LAST_FRAME - 1)) begin
                           state_q <= S_DONE;
                           frame_q <= NUM_W'(LAST_FRAME);
                           num_q   <= NUM_W'(LAST_FRAME);
                        end else begin
                           frame_q <= frame_q + 1'b1;
                           num_q   <= frame_q + 1'b1;
                        end
                     end else begin
                        warm_q <= warm_q + 1'b1;
                     end
                  end else if (cold_q == CW'(FAIL_SEC - 1)) begin
                     state_q <= S_FAIL;
                     num_q   <= NUM_W'(BLANK_NUM);
                  end else begin
                     cold_q <= cold_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (sec_tick)
                  num_q <= (num_q == NUM_W'(LAST_FRAME)) ? NUM_W'(LAST_FRAME - 1)
                                                        : NUM_W'(LAST_FRAME);
            end
            S_FAIL: num_q <= NUM_W'(BLANK_NUM);
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.num     = num_q;
   assign bus.busy    = (state_q == S_INCUBATE);
   assign bus.hatched = (state_q == S_DONE);
   assign bus.fail    = (state_q == S_FAIL);

endmodule

// File: tb/tb_hatch_seq.sv
// Directed bench for hatch_seq at CLK_HZ=4, STAGE_SEC=2, FAIL_SEC=3, LAST_FRAME=11.
module tb_hatch_seq;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   hatch_seq_if bus ();

   hatch_seq #(
      .CLK_HZ    (4),
      .STAGE_SEC (2),
      .FAIL_SEC  (3),
      .LAST_FRAME(11),
      .BLANK_NUM (15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int num, input int busy,
                          input int hatched, input int fail);
      chk({tag, ".num"},     int'(bus.num),     num);
      chk({tag, ".busy"},    int'(bus.busy),    busy);
      chk({tag, ".hatched"}, int'(bus.hatched), hatched);
      chk({tag, ".fail"},    int'(bus.fail),    fail);
   endtask

   initial begin
      // 1. reset with st held high
      rst = 1'b1; bus.st = 1'b1; bus.temp = 1'b1;
      step(2);
      chk_out("rst", 0, 0, 0, 0);
      rst = 1'b0;
      step(1);                       // edge E: IDLE -> INCUBATE
      chk_out("entry", 0, 1, 0, 0);

      // 2. warm run to hatch, then blink
      step(7);  chk("warm7.num", int'(bus.num), 0);
      step(1);  chk("warm8.num", int'(bus.num), 1);
      step(8);  chk("warm16.num", int'(bus.num), 2);
      step(71); chk_out("warm87", 10, 1, 0, 0);
      step(1);  chk_out("hatch88", 11, 0, 1, 0);
      bus.temp = 1'b0;               // ignored in DONE
      step(3);  chk("done91.num", int'(bus.num), 11);
      step(1);  chk_out("done92", 10, 0, 1, 0);
      step(4);  chk_out("done96", 11, 0, 1, 0);
      bus.st = 1'b0;
      step(1);  chk_out("done_abort", 0, 0, 0, 0);

      // 3. one warm second, two cold seconds, then warm again
      bus.st = 1'b1; bus.temp = 1'b1;
      step(1);                       // new E
      chk_out("run2.entry", 0, 1, 0, 0);
      step(4);
      bus.temp = 1'b0;
      step(8);  chk_out("cold12", 0, 1, 0, 0);
      bus.temp = 1'b1;
      step(3);  chk("warm15.num", int'(bus.num), 0);
      step(1);  chk_out("warm16", 1, 1, 0, 0);

      // 4. cold run of 2 broken by a warm tick, then a glitch, then real fail
      bus.temp = 1'b0;
      step(8);  chk_out("cold2", 1, 1, 0, 0);
      bus.temp = 1'b1;
      step(4);  chk_out("break", 1, 1, 0, 0);
      bus.temp = 1'b0;
      step(1);
      bus.temp = 1'b1;               // glitch between ticks
      step(1);
      bus.temp = 1'b0;
      step(6);  chk_out("cold2b", 1, 1, 0, 0);
      step(3);  chk("cold39.fail", int'(bus.fail), 0);
      step(1);  chk_out("fail40", 15, 0, 0, 1);
      bus.temp = 1'b1;
      step(8);  chk_out("fail_hold", 15, 0, 0, 1);

      // 6. st 1->0->1 out of FAIL restarts with a fresh prescale
      bus.st = 1'b0;
      step(1);  chk_out("fail_abort", 0, 0, 0, 0);
      step(3);  chk_out("idle_hold", 0, 0, 0, 0);
      bus.st = 1'b1;
      step(1);  chk_out("rerun.entry", 0, 1, 0, 0);
      step(7);  chk("rerun7.num", int'(bus.num), 0);
      step(1);  chk("rerun8.num", int'(bus.num), 1);

      // 5. st drop on the tick cycle that would advance the frame
      step(7);                       // next cycle is the second warm tick
      bus.st = 1'b0;
      step(1);  chk_out("tick_abort", 0, 0, 0, 0);
      bus.st = 1'b1;
      step(1);  chk_out("reentry", 0, 1, 0, 0);
      step(8);  chk("reentry8.num", int'(bus.num), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
